// File: rtl/rr_arb2x4_pkg.sv
// Shared constants and types for the 2-input round-robin arbiter.
// Holds the data width and the source tag encoding.
package rr_arb2x4_pkg;

  localparam int unsigned W = 4;

  typedef enum logic {
    SRC_I0 = 1'b0,
    SRC_I1 = 1'b1
  } src_e;

endpackage

// File: rtl/rr_arb2x4_mux.sv
// Mux2x4: 4-bit two-way data select used on the arbiter data path.
// Ports: I0/I1 data in, S select (1 picks I1), O selected data.
module Mux2x4
  import rr_arb2x4_pkg::*;
(
  input  logic [W-1:0] I0,
  input  logic [W-1:0] I1,
  input  logic         S,
  output logic [W-1:0] O
);

  assign O = S ? I1 : I0;

endmodule

// File: rtl/rr_arb2x4.sv
// rr_arb2x4: round-robin arbiter of two 4-bit valid/ready sources into
// one registered output beat with its source tag.
// Ports: CLK, RESET (sync, active-high);
//   I0/I0_valid/I0_ready, I1/I1_valid/I1_ready: input sources;
//   O/O_src/O_valid/O_ready: registered output stream.
module rr_arb2x4
  import rr_arb2x4_pkg::*;
(
  input  logic         CLK,
  input  logic         RESET,
  input  logic [W-1:0] I0,
  input  logic         I0_valid,
  output logic         I0_ready,
  input  logic [W-1:0] I1,
  input  logic         I1_valid,
  output logic         I1_ready,
  output logic [W-1:0] O,
  output logic         O_src,
  output logic         O_valid,
  input  logic         O_ready
);

  logic [W-1:0] data_q, data_d;
  src_e         src_q, src_d;
  logic         valid_q, valid_d;
  src_e         last_q, last_d;

  logic         load;
  logic         sel;
  logic         in_xfer;
  logic [W-1:0] mux_o;

  // Output slot is free when empty or being drained this cycle.
  assign load = !valid_q | O_ready;

  // I1 wins if alone, or in contention when I0 had the last grant.
  assign sel = I1_valid & (!I0_valid | (last_q == SRC_I0));

  assign I0_ready = load & !sel & !RESET;
  assign I1_ready = load &  sel & !RESET;

  assign in_xfer = (I0_valid & I0_ready) | (I1_valid & I1_ready);

  Mux2x4 u_mux (
    .I0 (I0),
    .I1 (I1),
    .S  (sel),
    .O  (mux_o)
  );

  always_comb begin
    data_d  = data_q;
    src_d   = src_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (in_xfer) begin
      data_d  = mux_o;
      src_d   = src_e'(sel);
      valid_d = 1'b1;
      last_d  = src_e'(sel);
    end else if (O_ready) begin
      valid_d = 1'b0;
    end
  end

  // Reset leaves last at I1 so I0 wins the first contention.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      data_q  <= '0;
      src_q   <= SRC_I0;
      valid_q <= 1'b0;
      last_q  <= SRC_I1;
    end else begin
      data_q  <= data_d;
      src_q   <= src_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign O       = data_q;
  assign O_src   = src_q;
  assign O_valid = valid_q;

endmodule

// File: tb/tb_rr_arb2x4.sv
// Directed self-checking bench for rr_arb2x4.
// Scenarios: reset, contention, single source, backpressure, drain, mid reset.
module tb_rr_arb2x4;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] I0, I1, O;
  logic       I0_valid, I1_valid;
  logic       I0_ready, I1_ready;
  logic       O_src, O_valid, O_ready;

  int tests = 0;
  int fails = 0;

  rr_arb2x4 dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .I0       (I0),
    .I0_valid (I0_valid),
    .I0_ready (I0_ready),
    .I1       (I1),
    .I1_valid (I1_valid),
    .I1_ready (I1_ready),
    .O        (O),
    .O_src    (O_src),
    .O_valid  (O_valid),
    .O_ready  (O_ready)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    I0 = 4'h3; I1 = 4'hC;
    I0_valid = 1'b1; I1_valid = 1'b1;
    O_ready = 1'b1;
    #1;
    tests++;
    if ({I0_ready, I1_ready} !== 2'b00) begin
      fails++;
      $display("FAIL reset_ready_comb got=%b exp=00", {I0_ready, I1_ready});
    end
    tick();
    tick();
    tests++;
    if ({O_valid, O, O_src, I0_ready, I1_ready} !== 8'b0) begin
      fails++;
      $display("FAIL reset_state got v=%b o=%h s=%b r=%b%b exp all 0",
               O_valid, O, O_src, I0_ready, I1_ready);
    end
  endtask

  task automatic test_contention();
    logic [3:0] exp_o [4];
    logic       exp_s [4];
    exp_o[0] = 4'h3; exp_o[1] = 4'hC; exp_o[2] = 4'h3; exp_o[3] = 4'hC;
    exp_s[0] = 1'b0; exp_s[1] = 1'b1; exp_s[2] = 1'b0; exp_s[3] = 1'b1;
    RESET = 1'b0;
    I0 = 4'h3; I1 = 4'hC;
    I0_valid = 1'b1; I1_valid = 1'b1;
    O_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++;
      if ({I0_ready, I1_ready} !== {~exp_s[i], exp_s[i]}) begin
        fails++;
        $display("FAIL contention_grant[%0d] got=%b%b exp=%b%b", i,
                 I0_ready, I1_ready, ~exp_s[i], exp_s[i]);
      end
      tick();
      tests++;
      if ({O_valid, O, O_src} !== {1'b1, exp_o[i], exp_s[i]}) begin
        fails++;
        $display("FAIL contention_beat[%0d] got v=%b o=%h s=%b exp v=1 o=%h s=%b",
                 i, O_valid, O, O_src, exp_o[i], exp_s[i]);
      end
    end
  endtask

  task automatic test_single_source();
    I0_valid = 1'b0; I1_valid = 1'b1;
    I1 = 4'h5;
    O_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if ({I0_ready, I1_ready} !== 2'b01) begin
        fails++;
        $display("FAIL single_ready[%0d] got=%b%b exp=01", i, I0_ready, I1_ready);
      end
      tick();
      tests++;
      if ({O_valid, O, O_src} !== {1'b1, 4'h5, 1'b1}) begin
        fails++;
        $display("FAIL single_beat[%0d] got v=%b o=%h s=%b exp v=1 o=5 s=1",
                 i, O_valid, O, O_src);
      end
    end
  endtask

  task automatic test_backpressure();
    I0 = 4'h9; I0_valid = 1'b1;
    I1_valid = 1'b0;
    O_ready = 1'b1;
    tick();
    tests++;
    if ({O_valid, O, O_src} !== {1'b1, 4'h9, 1'b0}) begin
      fails++;
      $display("FAIL bp_load got v=%b o=%h s=%b exp v=1 o=9 s=0",
               O_valid, O, O_src);
    end
    O_ready = 1'b0;
    I1 = 4'hC; I1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if ({I0_ready, I1_ready} !== 2'b00) begin
        fails++;
        $display("FAIL bp_ready[%0d] got=%b%b exp=00", i, I0_ready, I1_ready);
      end
      tick();
      tests++;
      if ({O_valid, O, O_src} !== {1'b1, 4'h9, 1'b0}) begin
        fails++;
        $display("FAIL bp_hold[%0d] got v=%b o=%h s=%b exp v=1 o=9 s=0",
                 i, O_valid, O, O_src);
      end
    end
    O_ready = 1'b1;
    tick();
    tests++;
    if ({O_valid, O, O_src} !== {1'b1, 4'hC, 1'b1}) begin
      fails++;
      $display("FAIL bp_release got v=%b o=%h s=%b exp v=1 o=c s=1",
               O_valid, O, O_src);
    end
  endtask

  task automatic test_drain();
    I0 = 4'h7; I0_valid = 1'b1;
    I1_valid = 1'b0;
    O_ready = 1'b1;
    tick();
    tests++;
    if ({O_valid, O, O_src} !== {1'b1, 4'h7, 1'b0}) begin
      fails++;
      $display("FAIL drain_beat got v=%b o=%h s=%b exp v=1 o=7 s=0",
               O_valid, O, O_src);
    end
    I0_valid = 1'b0;
    I0 = 4'hF;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++;
      if ({O_valid, O, O_src} !== {1'b0, 4'h7, 1'b0}) begin
        fails++;
        $display("FAIL drain_idle[%0d] got v=%b o=%h s=%b exp v=0 o=7 s=0",
                 i, O_valid, O, O_src);
      end
    end
  endtask

  task automatic test_mid_reset();
    I0 = 4'hA; I0_valid = 1'b1;
    I1_valid = 1'b0;
    O_ready = 1'b0;
    tick();
    I0_valid = 1'b0;
    tick();
    tests++;
    if ({O_valid, O} !== {1'b1, 4'hA}) begin
      fails++;
      $display("FAIL midrst_held got v=%b o=%h exp v=1 o=a", O_valid, O);
    end
    RESET = 1'b1;
    I0 = 4'h3; I1 = 4'hC;
    I0_valid = 1'b1; I1_valid = 1'b1;
    #1;
    tests++;
    if ({I0_ready, I1_ready} !== 2'b00) begin
      fails++;
      $display("FAIL midrst_ready got=%b%b exp=00", I0_ready, I1_ready);
    end
    tick();
    tests++;
    if ({O_valid, O, O_src} !== 6'b0) begin
      fails++;
      $display("FAIL midrst_clear got v=%b o=%h s=%b exp all 0",
               O_valid, O, O_src);
    end
    RESET = 1'b0;
    O_ready = 1'b1;
    #1;
    tests++;
    if ({I0_ready, I1_ready} !== 2'b10) begin
      fails++;
      $display("FAIL midrst_grant got=%b%b exp=10", I0_ready, I1_ready);
    end
    tick();
    tests++;
    if ({O_valid, O, O_src} !== {1'b1, 4'h3, 1'b0}) begin
      fails++;
      $display("FAIL midrst_beat got v=%b o=%h s=%b exp v=1 o=3 s=0",
               O_valid, O, O_src);
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_source();
    test_backpressure();
    test_drain();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rr_arb2x4.md
RR_ARB2X4 -- requirements
Module: rr_arb2x4

Interface
REQ-001 SHALL have no parameters; data width fixed at 4 bits.
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-004 SHALL have port I0  input  4  data from source 0.
REQ-005 SHALL have port I0_valid  input  1  source 0 offers I0.
REQ-006 SHALL have port I0_ready  output  1  source 0 transfer accepted this cycle.
REQ-007 SHALL have port I1  input  4  data from source 1.
REQ-008 SHALL have port I1_valid  input  1  source 1 offers I1.
REQ-009 SHALL have port I1_ready  output  1  source 1 transfer accepted this cycle.
REQ-010 SHALL have port O  output  4  registered arbitrated data.
REQ-011 SHALL have port O_src  output  1  registered source tag of O (0=I0, 1=I1).
REQ-012 SHALL have port O_valid  output  1  O/O_src hold a valid beat.
REQ-013 SHALL have port O_ready  input  1  consumer accepts O this cycle.

Function
REQ-014 SHALL define transfer on port Px as Px_valid & Px_ready at a rising edge; output transfer as O_valid & O_ready.
REQ-015 SHALL compute load = !O_valid | O_ready (one-entry pipeline register, combinational ready path).
REQ-016 SHALL compute grant select S = I1_valid & (!I0_valid | !last), where last is the registered source of the previous input transfer.
REQ-017 SHALL drive I0_ready = load & !S and I1_ready = load & S; at most one of I0_ready/I1_ready is high per cycle.
REQ-018 SHALL, when only one source is valid, grant that source regardless of last.
REQ-019 SHALL, when both sources are valid, grant the source not granted by the most recent input transfer (strict alternation under continuous contention).
REQ-020 SHALL, on an input transfer, load O <= selected data, O_src <= S, O_valid <= 1, last <= S, with latency one cycle from input transfer to O_valid.
REQ-021 SHALL, on output transfer with no input transfer in the same cycle, clear O_valid; O and O_src hold their last values.
REQ-022 SHALL, on simultaneous output and input transfer, replace the beat with no bubble (full throughput, one beat per cycle).
REQ-023 SHALL hold O, O_src, O_valid stable while O_valid & !O_ready (backpressure); I0_ready and I1_ready SHALL be 0 in that state.
REQ-024 SHALL leave last unchanged in cycles with no input transfer.
REQ-025 SHALL not depend on Px data when Px_valid is 0.

Reset
REQ-026 SHALL, while RESET is high at a rising edge, set O=0, O_src=0, O_valid=0, last=1 (so I0 wins first contention).
REQ-027 SHALL drive I0_ready=0 and I1_ready=0 while RESET is high; any beat held mid-operation is discarded.
REQ-028 SHALL resume normal arbitration on the first rising edge after RESET deasserts.

Structure
REQ-029 SHALL instantiate one Mux2x4 sub-module (I0, I1, S, O) as the data-select path, driven by S from REQ-016.
REQ-030 SHALL place grant FSM (last) and output register in rr_arb2x4; no shared package required, width constant 4 local.

Verification
REQ-031 SHALL test reset: assert RESET 2 cycles with I0_valid=I1_valid=1 -> O_valid=0, O=0, O_src=0, both readys 0.
REQ-032 SHALL test contention: I0=0x3, I1=0xC both valid, O_ready=1 for 4 cycles after reset -> O sequence 0x3,0xC,0x3,0xC with O_src 0,1,0,1, one per cycle.
REQ-033 SHALL test single source: only I1_valid=1, I1=0x5, 3 cycles -> three beats 0x5, O_src=1, I0_ready=0 throughout.
REQ-034 SHALL test backpressure: load 0x9 from I0, then O_ready=0 for 3 cycles with both valid -> O=0x9 held, O_valid=1, both readys 0; O_ready=1 -> next beat 0xC from I1.
REQ-035 SHALL test drain: single I0 beat 0x7 then no valids, O_ready=1 -> O_valid high exactly one cycle, then 0 with O=0x7 held.
REQ-036 SHALL test mid-operation reset: O_valid=1 with O=0xA, O_ready=0, assert RESET one cycle -> O_valid=0, O=0, next contention granted to I0.
